// File: rtl/register_file.sv
// 32 x 32-bit general-purpose register file: two combinational read ports and one
// clocked write port, with $0 hardwired to zero and optional write-to-read forwarding.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  output logic [DATA_WIDTH-1:0] BusA,
  output logic [DATA_WIDTH-1:0] BusB
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic                  wr_en;

  // Writes to $0 are dropped here, so entry 0 only ever holds its reset value.
  assign wr_en = RegWrite && (WriteRegister != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[WriteRegister] <= WriteData;
    end
  end

  // Reset and index 0 dominate; forwarding only applies to a live, non-zero write.
  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] idx);
    logic [DATA_WIDTH-1:0] val;
    val = '0;
    if (!reset && (idx != '0)) begin
      if ((BYPASS != 0) && wr_en && (WriteRegister == idx)) begin
        val = WriteData;
      end else begin
        val = regs_q[idx];
      end
    end
    return val;
  endfunction

  always_comb begin
    BusA = '0;
    BusB = '0;
    BusA = read_port(ReadRegister1);
    BusB = read_port(ReadRegister2);
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: one instance with forwarding and one without,
// both driven from the same inputs and checked against hand-computed values.
module tb_register_file;

  logic        clk;
  logic        clk_en;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic [4:0]  read_register1;
  logic [4:0]  read_register2;
  logic [31:0] bus_a_bp, bus_b_bp;
  logic [31:0] bus_a_nb, bus_b_nb;

  int n_checks;
  int n_fail;

  logic [31:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] ea_bp;
    logic [31:0] eb_bp;
    logic [31:0] ea_nb;
    logic [31:0] eb_nb;
  } vec_t;

  vec_t vecs[14];

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) dut_bp (
    .clk(clk), .reset(reset), .RegWrite(reg_write), .WriteRegister(write_register),
    .WriteData(write_data), .ReadRegister1(read_register1), .ReadRegister2(read_register2),
    .BusA(bus_a_bp), .BusB(bus_b_bp)
  );

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .RegWrite(reg_write), .WriteRegister(write_register),
    .WriteData(write_data), .ReadRegister1(read_register1), .ReadRegister2(read_register2),
    .BusA(bus_a_nb), .BusB(bus_b_nb)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = clk_en ? ~clk : 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    reg_write      = we;
    write_register = wa;
    write_data     = wd;
    read_register1 = r1;
    read_register2 = r2;
  endtask

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic [31:0] ea_bp, input logic [31:0] eb_bp,
                              input logic [31:0] ea_nb, input logic [31:0] eb_nb);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.r1 = r1; v.r2 = r2;
    v.ea_bp = ea_bp; v.eb_bp = eb_bp; v.ea_nb = ea_nb; v.eb_nb = eb_nb;
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      read_register1 = 5'(i);
      read_register2 = 5'(31 - i);
      #1;
      check({tag, "_bp_a"}, bus_a_bp, 32'h0);
      check({tag, "_bp_b"}, bus_b_bp, 32'h0);
      check({tag, "_nb_a"}, bus_a_nb, 32'h0);
      check({tag, "_nb_b"}, bus_b_nb, 32'h0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk_en   = 1'b0;
    reset    = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Reset pulse with the clock stopped, then every index reads zero.
    #3 reset = 1'b1;
    #3 reset = 1'b0;
    #2;
    check_all_zero("reset_noclk");

    // Each vector is applied after a falling edge and checked before the rising
    // edge that commits its write; columns are forwarding / non-forwarding.
    vecs[0]  = mk(1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0);
    vecs[1]  = mk(0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    vecs[2]  = mk(1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0);
    vecs[3]  = mk(0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF);
    vecs[4]  = mk(1, 5'd7,  32'h1,        5'd0,  5'd7,  32'h0,        32'h1,        32'h0,        32'h0);
    vecs[5]  = mk(1, 5'd7,  32'h2A,       5'd7,  5'd7,  32'h2A,       32'h2A,       32'h1,        32'h1);
    vecs[6]  = mk(0, 5'd0,  32'h0,        5'd7,  5'd5,  32'h2A,       32'hDEADBEEF, 32'h2A,       32'hDEADBEEF);
    vecs[7]  = mk(1, 5'd3,  32'h10,       5'd3,  5'd4,  32'h10,       32'h0,        32'h0,        32'h0);
    vecs[8]  = mk(1, 5'd3,  32'h20,       5'd3,  5'd4,  32'h20,       32'h0,        32'h10,       32'h0);
    vecs[9]  = mk(0, 5'd0,  32'h0,        5'd3,  5'd4,  32'h20,       32'h0,        32'h20,       32'h0);
    vecs[10] = mk(1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd7,  32'hA5A5A5A5, 32'h2A,       32'h0,        32'h2A);
    vecs[11] = mk(0, 5'd0,  32'h0,        5'd31, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
    vecs[12] = mk(1, 5'd5,  32'h12345678, 5'd7,  5'd5,  32'h2A,       32'h12345678, 32'h2A,       32'hDEADBEEF);
    vecs[13] = mk(0, 5'd0,  32'h0,        5'd5,  5'd0,  32'h12345678, 32'h0,        32'h12345678, 32'h0);

    clk_en = 1'b1;
    for (int v = 0; v < 14; v++) begin
      @(negedge clk);
      drive(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].r1, vecs[v].r2);
      #1;
      check($sformatf("vec%0d_bp_a", v), bus_a_bp, vecs[v].ea_bp);
      check($sformatf("vec%0d_bp_b", v), bus_b_bp, vecs[v].eb_bp);
      check($sformatf("vec%0d_nb_a", v), bus_a_nb, vecs[v].ea_nb);
      check($sformatf("vec%0d_nb_b", v), bus_b_nb, vecs[v].eb_nb);
    end

    // Same-index write without forwarding: old value before the edge, new after.
    @(negedge clk);
    drive(1'b1, 5'd7, 32'h55, 5'd7, 5'd7);
    #1 check("nb_pre_edge", bus_b_nb, 32'h2A);
    @(posedge clk);
    #1 check("nb_post_edge", bus_b_nb, 32'h55);
    check("bp_post_edge", bus_b_bp, 32'h55);

    // Fill r1..r31 with index * 0x01010101 and read it back through the scoreboard.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      drive(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0);
    end
    @(negedge clk);
    reg_write = 1'b0;
    for (int i = 0; i < 32; i++) exp_q.push_back(32'(i) * 32'h01010101);
    for (int i = 0; i < 32; i++) begin
      logic [31:0] e;
      read_register1 = 5'(i);
      read_register2 = 5'(i);
      #1;
      e = exp_q.pop_front();
      check($sformatf("fill_r%0d_a", i), bus_a_bp, e);
      check($sformatf("fill_r%0d_b", i), bus_b_nb, e);
    end

    // Mid-cycle reset: outputs drop immediately, and reset beats a write on the edge.
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd9);
    #1 check("pre_reset_a", bus_a_bp, 32'h05050505);
    check("pre_reset_b", bus_b_nb, 32'h09090909);
    #1 reset = 1'b1;
    #1 check("reset_now_bp_a", bus_a_bp, 32'h0);
    check("reset_now_bp_b", bus_b_bp, 32'h0);
    check("reset_now_nb_a", bus_a_nb, 32'h0);
    check("reset_now_nb_b", bus_b_nb, 32'h0);
    drive(1'b1, 5'd9, 32'hFFFF0000, 5'd9, 5'd9);
    #1 check("reset_bypass_blocked", bus_a_bp, 32'h0);
    @(posedge clk);
    #1 check("reset_edge_bp", bus_b_bp, 32'h0);
    @(negedge clk);
    reg_write = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_all_zero("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
